exc_sequencer: RTL and testbench

//  Exception/interrupt sequencer in front of coprocessor0's exception port.

---
 rtl/cp0_pkg.sv | 31 +++
 rtl/int_prio_enc.sv | 25 ++
 rtl/exc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_exc_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared types and constants for the coprocessor-0 exception sequencer.
package cp0_pkg;

  // Cause codes this sequencer produces or interprets.
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_ENTER,
    S_RETURN
  } seq_state_t;

  // Offset of the interrupt vector from the general exception vector.
  localparam logic [31:0] VEC_INT_OFS = 32'h80;

  // EPC points at the branch when the victim sits in its delay slot.
  // Plain 32-bit subtraction, so PC 0 wraps to 32'hFFFFFFFC.
  function automatic logic [31:0] epc_adj(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Masked interrupt priority encoder: counter (IP7) wins, then the highest
// external line index. ext[i] maps to IP(i+2).
module int_prio_enc #(
  parameter int N_EXT = 5
) (
  input  logic             counter,
  input  logic [N_EXT-1:0] ext,
  input  logic [N_EXT:0]   im,
  output logic             pending,
  output logic [2:0]       id
);

  logic [N_EXT:0] req;

  // Scan low to high so the highest active line overwrites the index.
  always_comb begin
    req     = {counter, ext} & im;
    pending = |req;
    id      = 3'd0;
    for (int i = 0; i < N_EXT; i++)
      if (req[i]) id = 3'(i + 2);
    if (req[N_EXT]) id = 3'd7;
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception / interrupt / ERET sequencer in front of cp0's exception port.
// Accepts one event in IDLE, holds a pipeline flush until acknowledged, then
// emits a single-cycle entry or return strobe with a fetch redirect.
// Optional build macro VECTORED_INT_EN: interrupts go to VEC_BASE+0x80 and the
// winning IP index is exported on int_id.
module exc_sequencer
  import cp0_pkg::*;
#(
  parameter int          N_EXT    = 5,
  parameter logic [31:0] VEC_BASE = 32'h00000180
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [31:0]      exc_pc,
  input  logic             exc_bd,
  input  logic [31:0]      exc_va,
  input  logic [31:0]      ret_pc,
  input  logic             ret_bd,
  input  logic             ien_wb,
  input  logic             int_counter,
  input  logic [N_EXT-1:0] int_ext,
  input  logic [7:0]       int_mask,
  input  logic             int_enable,
  input  logic             exl,
  input  logic             eret_req,
  input  logic [31:0]      epc_q,
  input  logic             flush_ack,
  output logic             flush_req,
  output logic             e_enter,
  output logic             eret,
  output logic [4:0]       cause,
  output logic             delay_slot,
  output logic [31:0]      epc,
  output logic [31:0]      bad_va,
  output logic             redir_valid,
  output logic [31:0]      redir_pc
`ifdef VECTORED_INT_EN
  ,
  output logic [2:0]       int_id
`endif
);

  seq_state_t  state, state_n;
  logic        enc_pending, int_pend;
  logic [2:0]  win_id;
  logic        acc_exc, acc_int, acc_ret;
  logic        ret_r;
  logic [4:0]  cause_r;
  logic        bd_r;
  logic [31:0] epc_r, bad_va_r;
  logic        unused_im;

  // Software interrupt bits IM[1:0] are not sequenced here.
  assign unused_im = ^int_mask[6-N_EXT:0];

  int_prio_enc #(.N_EXT(N_EXT)) u_prio (
    .counter (int_counter),
    .ext     (int_ext),
    .im      (int_mask[7 -: N_EXT+1]),
    .pending (enc_pending),
    .id      (win_id)
  );

  assign int_pend = ien_wb & int_enable & ~exl & enc_pending;
  assign acc_exc  = exc_valid;
  assign acc_int  = ~exc_valid & int_pend;
  assign acc_ret  = ~exc_valid & ~int_pend & eret_req & exl;

`ifdef VECTORED_INT_EN
  logic       int_r;
  logic [2:0] int_id_r;
  assign int_id = int_id_r;
`else
  logic unused_id;
  assign unused_id = ^win_id;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state and strobe/redirect decode.
  always_comb begin
    state_n     = state;
    flush_req   = 1'b0;
    e_enter     = 1'b0;
    eret        = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    case (state)
      S_IDLE:   if (acc_exc | acc_int | acc_ret) state_n = S_FLUSH;
      S_FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) state_n = ret_r ? S_RETURN : S_ENTER;
      end
      S_ENTER: begin
        e_enter     = 1'b1;
        redir_valid = 1'b1;
`ifdef VECTORED_INT_EN
        redir_pc    = int_r ? (VEC_BASE + VEC_INT_OFS) : VEC_BASE;
`else
        redir_pc    = VEC_BASE;
`endif
        state_n     = S_IDLE;
      end
      S_RETURN: begin
        eret        = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = epc_q;
        state_n     = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Capture the accepted event; values hold until the next acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ret_r    <= 1'b0;
      cause_r  <= 5'd0;
      bd_r     <= 1'b0;
      epc_r    <= 32'd0;
      bad_va_r <= 32'd0;
`ifdef VECTORED_INT_EN
      int_r    <= 1'b0;
      int_id_r <= 3'd0;
`endif
    end else if (state == S_IDLE) begin
      if (acc_exc) begin
        ret_r    <= 1'b0;
        cause_r  <= exc_code;
        bd_r     <= exc_bd;
        epc_r    <= epc_adj(exc_pc, exc_bd);
        bad_va_r <= (exc_code == EXC_ADEL || exc_code == EXC_ADES) ? exc_va : 32'd0;
`ifdef VECTORED_INT_EN
        int_r    <= 1'b0;
        int_id_r <= 3'd0;
`endif
      end else if (acc_int) begin
        ret_r    <= 1'b0;
        cause_r  <= EXC_INT;
        bd_r     <= ret_bd;
        epc_r    <= epc_adj(ret_pc, ret_bd);
        bad_va_r <= 32'd0;
`ifdef VECTORED_INT_EN
        int_r    <= 1'b1;
        int_id_r <= win_id;
`endif
      end else if (acc_ret) begin
        ret_r    <= 1'b1;
      end
    end
  end

  assign cause      = cause_r;
  assign delay_slot = bd_r;
  assign epc        = epc_r;
  assign bad_va     = bad_va_r;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: stimulus pushes expected strobes,
// a negedge monitor pops and compares whenever E_ENTER or ERET fires.
module tb_exc_sequencer;

  localparam int N_EXT = 5;
`ifdef VECTORED_INT_EN
  localparam logic [31:0] INT_VEC = 32'h200;
`else
  localparam logic [31:0] INT_VEC = 32'h180;
`endif

  logic clk = 0, reset_n;
  logic exc_valid, exc_bd, ret_bd, ien_wb, int_counter, int_enable, exl, eret_req, flush_ack;
  logic [4:0] exc_code;
  logic [31:0] exc_pc, exc_va, ret_pc, epc_q;
  logic [N_EXT-1:0] int_ext;
  logic [7:0] int_mask;
  logic flush_req, e_enter, eret, delay_slot, redir_valid;
  logic [4:0] cause;
  logic [31:0] epc, bad_va, redir_pc;
`ifdef VECTORED_INT_EN
  logic [2:0] int_id;
`endif

  exc_sequencer #(.N_EXT(N_EXT), .VEC_BASE(32'h180)) dut (
    .clk(clk), .reset_n(reset_n), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_va(exc_va), .ret_pc(ret_pc), .ret_bd(ret_bd),
    .ien_wb(ien_wb), .int_counter(int_counter), .int_ext(int_ext), .int_mask(int_mask),
    .int_enable(int_enable), .exl(exl), .eret_req(eret_req), .epc_q(epc_q),
    .flush_ack(flush_ack), .flush_req(flush_req), .e_enter(e_enter), .eret(eret),
    .cause(cause), .delay_slot(delay_slot), .epc(epc), .bad_va(bad_va),
    .redir_valid(redir_valid), .redir_pc(redir_pc)
`ifdef VECTORED_INT_EN
    , .int_id(int_id)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ret;
    logic [4:0]  cause;
    logic        bd;
    logic [31:0] epc;
    logic [31:0] bva;
    logic [31:0] redir;
    logic [2:0]  id;
    bit          is_int;
    int          flush;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int fcnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(bit ret, logic [4:0] c, logic bd, logic [31:0] pc, logic [31:0] bva,
                      logic [31:0] redir, logic [2:0] id, bit is_int, int fl);
    exp_t x;
    x.ret = ret; x.cause = c; x.bd = bd; x.epc = pc; x.bva = bva;
    x.redir = redir; x.id = id; x.is_int = is_int; x.flush = fl;
    q.push_back(x);
  endtask

  // Monitor: count flush cycles, compare every strobe against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) fcnt = 0;
    else begin
      if (flush_req) fcnt++;
      if (e_enter || eret) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got e_enter=%0b eret=%0b expected none", e_enter, eret);
        end else begin
          e = q.pop_front();
          chk("eret", {31'd0, eret}, {31'd0, e.ret});
          chk("e_enter", {31'd0, e_enter}, {31'd0, !e.ret});
          chk("redir_valid", {31'd0, redir_valid}, 32'd1);
          chk("redir_pc", redir_pc, e.redir);
          chk("flush_cycles", fcnt, e.flush);
          chk("flush_req_at_strobe", {31'd0, flush_req}, 32'd0);
          if (!e.ret) begin
            chk("cause", {27'd0, cause}, {27'd0, e.cause});
            chk("delay_slot", {31'd0, delay_slot}, {31'd0, e.bd});
            chk("epc", epc, e.epc);
            chk("bad_va", bad_va, e.bva);
`ifdef VECTORED_INT_EN
            if (e.is_int) chk("int_id", {29'd0, int_id}, {29'd0, e.id});
`endif
          end
        end
        fcnt = 0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    exc_valid = 0; eret_req = 0; int_counter = 0; int_ext = '0;
  endtask

  // Request already driven: let it be accepted, then ack after k flush cycles.
  task automatic accept_ack(int k);
    cyc(1);
    clr();
    if (k > 1) cyc(k - 1);
    flush_ack = 1;
    cyc(1);
    flush_ack = 0;
    cyc(3);
  endtask

  initial begin
    reset_n = 0; clr(); flush_ack = 0;
    exc_code = 0; exc_pc = 0; exc_bd = 0; exc_va = 0; ret_pc = 0; ret_bd = 0;
    ien_wb = 0; int_mask = 0; int_enable = 0; exl = 0; epc_q = 0;
    cyc(3);
    chk("rst_flush_req", {31'd0, flush_req}, 32'd0);
    chk("rst_e_enter", {31'd0, e_enter}, 32'd0);
    chk("rst_eret", {31'd0, eret}, 32'd0);
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_cause", {27'd0, cause}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_bad_va", bad_va, 32'd0);
    reset_n = 1;
    cyc(2);

    // 1. Overflow, ack two cycles after acceptance.
    exc_valid = 1; exc_code = 12; exc_pc = 32'h400; exc_bd = 0; exc_va = 32'hDEAD;
    push(0, 12, 0, 32'h400, 32'h0, 32'h180, 0, 0, 2);
    accept_ack(2);

    // 2. AdEL in a delay slot; a second exception during FLUSH must be ignored.
    exc_valid = 1; exc_code = 4; exc_pc = 32'h1004; exc_bd = 1; exc_va = 32'h33;
    push(0, 4, 1, 32'h1000, 32'h33, 32'h180, 0, 0, 1);
    cyc(1);
    exc_code = 9; exc_pc = 32'h9990; exc_bd = 0; exc_va = 32'h77;
    flush_ack = 1;
    cyc(1);
    clr(); flush_ack = 0;
    cyc(3);

    // 3. Counter and ext[4] together: counter (IP7) wins.
    int_mask = 8'hFF; int_enable = 1; exl = 0; ien_wb = 1;
    ret_pc = 32'h2468; ret_bd = 0;
    int_counter = 1; int_ext = 5'b10000;
    push(0, 0, 0, 32'h2468, 32'h0, INT_VEC, 3'd7, 1, 1);
    accept_ack(1);
    // ext[3] and ext[1]: IP5 wins; RET_BD adjusts EPC.
    ret_pc = 32'h3000; ret_bd = 1; int_ext = 5'b01010;
    push(0, 0, 1, 32'h2FFC, 32'h0, INT_VEC, 3'd5, 1, 2);
    accept_ack(2);
    // ext[1] masked off by IM3 = 0: no action.
    int_mask = 8'hF7; int_ext = 5'b00010;
    cyc(4);
    chk("masked_int_no_flush", {31'd0, flush_req}, 32'd0);
    clr(); int_mask = 8'hFF;
    cyc(2);

    // 4. Exception beats simultaneous ERET.
    exl = 1;
    exc_valid = 1; exc_code = 8; exc_pc = 32'h800; exc_bd = 0; eret_req = 1;
    push(0, 8, 0, 32'h800, 32'h0, 32'h180, 0, 0, 1);
    accept_ack(1);
    // Pending interrupt while EXL=1 is never taken.
    int_counter = 1; int_ext = 5'b11111;
    cyc(5);
    chk("int_exl_no_flush", {31'd0, flush_req}, 32'd0);
    clr();
    cyc(2);

    // 5. ERET with EXL=1 returns to EPC_Q.
    epc_q = 32'h5550; eret_req = 1;
    push(1, 0, 0, 0, 0, 32'h5550, 0, 0, 2);
    accept_ack(2);
    // ERET with EXL=0 does nothing.
    exl = 0; eret_req = 1;
    cyc(1); clr();
    cyc(3);
    chk("eret_noexl_no_flush", {31'd0, flush_req}, 32'd0);

    // 6. Reset during FLUSH: back to IDLE, no strobe, latches cleared.
    ien_wb = 0;
    exc_valid = 1; exc_code = 12; exc_pc = 32'h700; exc_bd = 0;
    cyc(1); clr();
    chk("flush_before_reset", {31'd0, flush_req}, 32'd1);
    reset_n = 0;
    cyc(1);
    chk("reset_flush_req", {31'd0, flush_req}, 32'd0);
    chk("reset_cause", {27'd0, cause}, 32'd0);
    chk("reset_epc", epc, 32'd0);
    reset_n = 1; flush_ack = 1;
    cyc(2);
    flush_ack = 0;
    chk("after_reset_idle", {31'd0, flush_req}, 32'd0);
    // PC 0 in a delay slot wraps EPC.
    exc_valid = 1; exc_code = 10; exc_pc = 32'h0; exc_bd = 1;
    push(0, 10, 1, 32'hFFFFFFFC, 32'h0, 32'h180, 0, 0, 1);
    accept_ack(1);

    cyc(5);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
